// File: rtl/hd_imem_loader_pkg.sv
// hd_imem_loader_pkg
// Shared constants for the HD-to-instruction-memory program loader:
// geometry of process slots and HD tracks, the opcode list (FIM marks the
// last word of a program), loader error codes and the loader FSM encoding.
package hd_imem_loader_pkg;

  localparam int unsigned BLOCK_SIZE    = 200;
  localparam int unsigned NUM_SLOTS     = 10;
  localparam int unsigned HD_TRACK_SIZE = 200;
  localparam int unsigned NUM_PROGS     = 16;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b000100;
  localparam logic [5:0] OP_SW   = 6'b000101;
  localparam logic [5:0] OP_BEQ  = 6'b000110;
  localparam logic [5:0] OP_JMP  = 6'b000111;
  localparam logic [5:0] OP_FIM  = 6'b011111;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_TRUNC = 2'b10
  } err_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

endpackage

// File: rtl/hd_imem_loader_addr_gen.sv
// hd_imem_loader_addr_gen
// Word address of a fixed-size region: addr = base * SIZE + offset.
// Used once for the HD track address and once for the imem slot address.
//   base   in  5   region index (slot or program)
//   offset in  8   word offset inside the region
//   addr   out 32  resulting word address
module hd_imem_loader_addr_gen #(
  parameter int unsigned SIZE = 200
) (
  input  logic [4:0]  base,
  input  logic [7:0]  offset,
  output logic [31:0] addr
);

  assign addr = 32'(base) * SIZE + 32'(offset);

endmodule

// File: rtl/hd_imem_loader.sv
// hd_imem_loader
// Copies one program from the HD model into a process slot of instruction
// memory, one 32-bit word per HD read, stopping after the FIM word or when
// the slot is full.
// Optional build macro: LOADER_CHECKSUM_EN (running 32-bit sum of written
// words on checksum; without it checksum is tied to 0).
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   start, slot, prog         load request, destination slot, source program
//   hd_rd_req/addr/valid/data HD read handshake
//   imem_we/addr/data         instruction-memory program-write port
//   load_end                  end-of-load strobe towards instruction memory
//   busy, done, err, words    status; err/words valid with done
//   checksum                  sum of written words (optional)
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | range check of latched slot/prog
// REQ    | HD read request issued for current offset
// WAIT   | holding request until HD data valid
// WRITE  | word on imem port; decide end of program / next word
// FINISH | done + load_end pulse
module hd_imem_loader
  import hd_imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  slot,
  input  logic [4:0]  prog,
  output logic        hd_rd_req,
  output logic [31:0] hd_rd_addr,
  input  logic        hd_rd_valid,
  input  logic [31:0] hd_rd_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        load_end,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [7:0]  words,
  output logic [31:0] checksum
);

  localparam logic [4:0] SLOT_LIMIT  = 5'(NUM_SLOTS);
  localparam logic [4:0] PROG_LIMIT  = 5'(NUM_PROGS);
  localparam logic [7:0] LAST_OFFSET = 8'(BLOCK_SIZE - 1);

  state_t      state;
  logic [4:0]  slot_q;
  logic [4:0]  prog_q;
  logic [7:0]  offset;
  logic [5:0]  op_q;
  logic [7:0]  rd_offset;
  logic [31:0] hd_addr_w;
  logic [31:0] imem_addr_w;

  // The HD address is registered on entry to REQ, so it is generated for the
  // offset about to be requested: 0 from CHECK, offset+1 from WRITE.
  assign rd_offset = (state == S_WRITE) ? offset + 8'd1 : 8'd0;

  hd_imem_loader_addr_gen #(.SIZE(HD_TRACK_SIZE)) u_hd_addr (
    .base   (prog_q),
    .offset (rd_offset),
    .addr   (hd_addr_w)
  );

  hd_imem_loader_addr_gen #(.SIZE(BLOCK_SIZE)) u_imem_addr (
    .base   (slot_q),
    .offset (offset),
    .addr   (imem_addr_w)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      slot_q     <= '0;
      prog_q     <= '0;
      offset     <= '0;
      op_q       <= '0;
      hd_rd_req  <= 1'b0;
      hd_rd_addr <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_data  <= '0;
      load_end   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_OK;
      words      <= '0;
    end else begin
      imem_we  <= 1'b0;
      done     <= 1'b0;
      load_end <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            slot_q <= slot;
            prog_q <= prog;
            err    <= ERR_OK;
            words  <= '0;
            busy   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (slot_q >= SLOT_LIMIT || prog_q >= PROG_LIMIT) begin
            err      <= ERR_RANGE;
            busy     <= 1'b0;
            done     <= 1'b1;
            load_end <= 1'b1;
            state    <= S_FINISH;
          end else begin
            offset     <= '0;
            hd_rd_req  <= 1'b1;
            hd_rd_addr <= hd_addr_w;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Write strobe is registered here so it is high during WRITE.
          if (hd_rd_valid) begin
            op_q      <= hd_rd_data[31:26];
            hd_rd_req <= 1'b0;
            imem_we   <= 1'b1;
            imem_addr <= imem_addr_w;
            imem_data <= hd_rd_data;
            words     <= words + 8'd1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (op_q == OP_FIM || offset == LAST_OFFSET) begin
            if (op_q != OP_FIM) err <= ERR_TRUNC;
            busy     <= 1'b0;
            done     <= 1'b1;
            load_end <= 1'b1;
            state    <= S_FINISH;
          end else begin
            offset     <= offset + 8'd1;
            hd_rd_req  <= 1'b1;
            hd_rd_addr <= hd_addr_w;
            state      <= S_REQ;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == S_IDLE && start) begin
      checksum <= '0;
    end else if (state == S_WAIT && hd_rd_valid) begin
      checksum <= checksum + hd_rd_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_hd_imem_loader.sv
// tb_hd_imem_loader
// Bench for hd_imem_loader: an HD responder with programmable delay, a
// monitor collecting imem writes and HD read addresses, and a reference
// model that derives the expected writes, err, words and checksum directly
// from the HD contents.
module tb_hd_imem_loader;

  localparam int BS    = 200;
  localparam int TRACK = 200;
  localparam int NSLOT = 10;
  localparam int NPROG = 16;
  localparam int LIMIT = 3000;
  localparam logic [5:0] FIM = 6'b011111;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  slot;
  logic [4:0]  prog;
  logic        hd_rd_req;
  logic [31:0] hd_rd_addr;
  logic        hd_rd_valid;
  logic [31:0] hd_rd_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        load_end;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [7:0]  words;
  logic [31:0] checksum;

  int n_vec = 0;
  int n_miscmp = 0;

  int hd_delay = 0;
  logic [31:0] hd_mem [int];

  logic [63:0] wr_q [$];
  logic [31:0] rd_q [$];
  int req_cnt = 0;
  int done_cnt = 0;
  int glitch = 0;

  logic [63:0] exp_q [$];
  int exp_err, exp_words;
  logic [31:0] exp_sum;

  hd_imem_loader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .slot        (slot),
    .prog        (prog),
    .hd_rd_req   (hd_rd_req),
    .hd_rd_addr  (hd_rd_addr),
    .hd_rd_valid (hd_rd_valid),
    .hd_rd_data  (hd_rd_data),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .load_end    (load_end),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words       (words),
    .checksum    (checksum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hd_word(input int a);
    if (hd_mem.exists(a)) return hd_mem[a];
    return 32'h0;
  endfunction

  // HD: one valid pulse per request, hd_delay cycles after the request's
  // first cycle plus one.
  initial begin : hd_model
    bit armed;
    int cnt;
    bit req_q;
    logic [31:0] a;
    armed = 0; cnt = 0; req_q = 0; a = 0;
    hd_rd_valid = 1'b0;
    hd_rd_data  = '0;
    forever begin
      @(posedge clock); #1;
      hd_rd_valid = 1'b0;
      if (armed) begin
        if (cnt == 0) begin
          hd_rd_valid = 1'b1;
          hd_rd_data  = hd_word(int'(a));
          armed = 0;
        end else begin
          cnt--;
        end
      end
      if (hd_rd_req && !req_q) begin
        armed = 1;
        cnt   = hd_delay;
        a     = hd_rd_addr;
      end
      req_q = hd_rd_req;
    end
  end

  logic        req_p = 1'b0;
  logic        val_p = 1'b0;
  logic [31:0] addr_p = '0;
  always @(negedge clock) begin
    if (imem_we) wr_q.push_back({imem_addr, imem_data});
    if (hd_rd_valid && hd_rd_req) rd_q.push_back(hd_rd_addr);
    if (hd_rd_req) req_cnt++;
    if (done) done_cnt++;
    if (load_end !== done) glitch++;
    if (req_p && hd_rd_req && hd_rd_addr !== addr_p) glitch++;
    if (req_p && !hd_rd_req && !val_p) glitch++;
    req_p  = hd_rd_req;
    val_p  = hd_rd_valid;
    addr_p = hd_rd_addr;
  end

  task automatic model(input int s, input int p);
    exp_q.delete();
    exp_err = 0; exp_words = 0; exp_sum = 0;
    if (s >= NSLOT || p >= NPROG) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < BS; i++) begin
      logic [31:0] w;
      w = hd_word(p * TRACK + i);
      exp_q.push_back({32'(s * BS + i), w});
      exp_words++;
      exp_sum += w;
      if (w[31:26] == FIM) return;
    end
    exp_err = 2;
  endtask

  task automatic put_prog(input int p, input int len, input bit with_fim);
    for (int i = 0; i < len; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == FIM) w[26] = ~w[26];
      hd_mem[p * TRACK + i] = w;
    end
    if (with_fim) hd_mem[p * TRACK + len - 1] = {FIM, 26'($urandom)};
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({hd_rd_req, imem_we, load_end, busy, done, err}), 64'h0);
    chk({tag, "_addr"}, {hd_rd_addr, imem_addr}, 64'h0);
    chk({tag, "_data"}, {imem_data, checksum}, 64'h0);
    chk({tag, "_words"}, 64'(words), 64'h0);
  endtask

  task automatic do_load(input int s, input int p, input int d, input bit mid);
    int w0, r0, q0, g0, cyc, busy_bad, lat;
    model(s, p);
    @(negedge clock);
    hd_delay = d;
    w0 = wr_q.size(); r0 = rd_q.size(); q0 = req_cnt; g0 = glitch;
    start = 1'b1; slot = 5'(s); prog = 5'(p);
    @(negedge clock);
    start = 1'b0;
    cyc = 1; busy_bad = 0;
    while (!done && cyc < LIMIT) begin
      if (!busy) busy_bad++;
      if (mid && cyc == 10) begin
        start = 1'b1; slot = 5'd0; prog = 5'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk("timeout", 64'(cyc < LIMIT), 64'h1);
    lat = (exp_err == 1) ? 2 : (3 + d) * exp_words + 2;
    chk("latency", 64'(cyc), 64'(lat));
    chk("busy_during", 64'(busy_bad), 64'h0);
    chk("err", 64'(err), 64'(exp_err));
    chk("words", 64'(words), 64'(exp_words));
    chk("load_end", 64'(load_end), 64'h1);
    chk("busy_at_done", 64'(busy), 64'h0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(exp_sum));
`else
    chk("checksum", 64'(checksum), 64'h0);
`endif
    @(negedge clock);
    chk("done_pulse", 64'({done, busy}), 64'h0);
    chk("proto", 64'(glitch - g0), 64'h0);
    chk("n_writes", 64'(wr_q.size() - w0), 64'(exp_q.size()));
    chk("n_reads", 64'(rd_q.size() - r0), 64'(exp_q.size()));
    if (exp_err == 1) chk("no_req", 64'(req_cnt - q0), 64'h0);
    for (int i = 0; i < exp_q.size() && (w0 + i) < wr_q.size(); i++) begin
      chk("write", wr_q[w0 + i], exp_q[i]);
    end
    for (int i = 0; i < exp_q.size() && (r0 + i) < rd_q.size(); i++) begin
      chk("hd_addr", 64'(rd_q[r0 + i]), 64'(p * TRACK + i));
    end
  endtask

  task automatic reset_mid();
    int w0, d0, nwr, cyc;
    put_prog(4, 5, 1'b1);
    @(negedge clock);
    hd_delay = 0;
    w0 = wr_q.size(); d0 = done_cnt;
    start = 1'b1; slot = 5'd5; prog = 5'd4;
    @(negedge clock);
    start = 1'b0;
    nwr = 0; cyc = 0;
    while (nwr < 2 && cyc < 200) begin
      if (imem_we) nwr++;
      if (nwr < 2) begin
        @(negedge clock);
        cyc++;
      end
    end
    chk("rst_reach", 64'(nwr), 64'h2);
    reset = 1'b1;
    @(negedge clock);
    check_zero("rst_mid");
    reset = 1'b0;
    repeat (12) @(negedge clock);
    chk("rst_no_done", 64'(done_cnt - d0), 64'h0);
    chk("rst_writes", 64'(wr_q.size() - w0), 64'h2);
    chk("rst_idle", 64'({busy, hd_rd_req, imem_we}), 64'h0);
    do_load(5, 4, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; slot = '0; prog = '0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    // slot 2, prog 3: three words ending in FIM
    hd_mem[600] = 32'h0400_0005;
    hd_mem[601] = 32'h0C00_0001;
    hd_mem[602] = 32'h7C00_0000;
    do_load(2, 3, 0, 1'b0);

    // out-of-range slot and program, including the first illegal values
    do_load(12, 3, 0, 1'b0);
    do_load(10, 3, 0, 1'b0);
    do_load(2, 16, 0, 1'b0);

    // no FIM: truncated at the last word of the last slot
    put_prog(5, 250, 1'b0);
    do_load(9, 5, 0, 1'b0);

    // slow HD with an ignored start mid-load
    put_prog(6, 6, 1'b1);
    do_load(1, 6, 5, 1'b1);

    reset_mid();

    // checksum pattern
    hd_mem[7 * TRACK + 0] = 32'h0000_0001;
    hd_mem[7 * TRACK + 1] = 32'h0000_0002;
    hd_mem[7 * TRACK + 2] = 32'h7C00_0000;
    do_load(0, 7, 0, 1'b0);

    // FIM as the very last word of a slot: not truncated
    put_prog(8, 200, 1'b1);
    do_load(3, 8, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      int s, p, d, len;
      s = $urandom_range(0, 11);
      p = $urandom_range(0, 17);
      d = $urandom_range(0, 3);
      len = $urandom_range(1, 210);
      if (p < NPROG) put_prog(p, len, len <= BS);
      do_load(s, p, d, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
